// File: rtl/pixel_writer.sv
// Receives the rasterizer's bit-serial pixel stream, converts Q10.6 coordinates to
// screen addresses, clips to the screen and queues writes for the framebuffer port.
module pixel_writer #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 4,
    parameter int FRAC       = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PX,
    input  logic              PY,
    input  logic              C,
    input  logic              FRAME,
    input  logic              VALID,
    input  logic              DONE,
    output logic              FB_WE,
    output logic [ADDR_W-1:0] FB_ADDR,
    output logic [15:0]       FB_DATA,
    input  logic              FB_READY,
    output logic              TRI_DONE,
    output logic [16:0]       PIX_CNT,
    output logic [16:0]       CLIP_CNT,
    output logic              OVF,
    output logic              ERR
);

    localparam int IW    = 16 - FRAC;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW    = ADDR_W + 16;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [14:0]     px_sr_q, px_sr_d;
    logic [14:0]     py_sr_q, py_sr_d;
    logic [14:0]     c_sr_q, c_sr_d;
    logic            valid_lat_q, valid_lat_d;
    logic            err_q, err_d;
    logic            word_done;

    logic            cv_pend_q, cv_pend_d;
    logic            cv_valid_q, cv_valid_d;
    logic [IW-1:0]   cv_xi_q, cv_xi_d;
    logic [IW-1:0]   cv_yi_q, cv_yi_d;
    logic [15:0]     cv_c_q, cv_c_d;

    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [EW-1:0]   mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]  count_q, count_d;
    logic            ovf_q, ovf_d;

    logic            done_pend_q, done_pend_d;
    logic [16:0]     pix_cnt_q, pix_cnt_d;
    logic [16:0]     clip_cnt_q, clip_cnt_d;

    logic            in_range;
    logic            push_req;
    logic            clip_hit;
    logic            push_ok;
    logic            pop;
    logic            empty;
    logic            full;
    logic            tri_done;
    logic [ADDR_W-1:0] addr;

    // Capture: a FRAME cycle always restarts the word at bit 15, even mid-word.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        px_sr_d     = px_sr_q;
        py_sr_d     = py_sr_q;
        c_sr_d      = c_sr_q;
        valid_lat_d = valid_lat_q;
        err_d       = err_q;
        word_done   = 1'b0;
        if (FRAME) begin
            state_d     = SHIFT;
            cnt_d       = 4'd14;
            px_sr_d     = {{14{1'b0}}, PX};
            py_sr_d     = {{14{1'b0}}, PY};
            c_sr_d      = {{14{1'b0}}, C};
            valid_lat_d = VALID;
            if (state_q == SHIFT) begin
                err_d = 1'b1;
            end
        end else begin
            case (state_q)
                SHIFT: begin
                    px_sr_d = {px_sr_q[13:0], PX};
                    py_sr_d = {py_sr_q[13:0], PY};
                    c_sr_d  = {c_sr_q[13:0], C};
                    cnt_d   = cnt_q - 4'd1;
                    if (cnt_q == 4'd0) begin
                        word_done = 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Only the integer part of each coordinate is kept; the word's bit k sits at
    // shift-register bit k-1 during the bit-0 cycle.
    always_comb begin
        cv_pend_d  = word_done;
        cv_valid_d = cv_valid_q;
        cv_xi_d    = cv_xi_q;
        cv_yi_d    = cv_yi_q;
        cv_c_d     = cv_c_q;
        if (word_done) begin
            cv_valid_d = valid_lat_q;
            cv_xi_d    = px_sr_q[14:FRAC-1];
            cv_yi_d    = py_sr_q[14:FRAC-1];
            cv_c_d     = {c_sr_q, C};
        end
    end

    always_comb begin
        in_range = !cv_xi_q[IW-1] && !cv_yi_q[IW-1] &&
                   (32'(cv_xi_q) < WIDTH) && (32'(cv_yi_q) < HEIGHT);
        addr     = ADDR_W'(cv_yi_q) * ADDR_W'(WIDTH) + ADDR_W'(cv_xi_q);
        push_req = cv_pend_q && cv_valid_q && in_range;
        clip_hit = cv_pend_q && cv_valid_q && !in_range;
    end

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == (PTR_W+1)'(FIFO_DEPTH));
        pop      = !empty && FB_READY;
        push_ok  = push_req && (!full || pop);
        tri_done = done_pend_q && (state_q == IDLE) && !cv_pend_q && empty;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = {addr, cv_c_q};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end
    end

    // Counters clear the cycle after the TRI_DONE pulse; a DONE in the pulse cycle is absorbed.
    always_comb begin
        done_pend_d = tri_done ? 1'b0 : (done_pend_q || DONE);
        pix_cnt_d   = pix_cnt_q;
        clip_cnt_d  = clip_cnt_q;
        if (tri_done) begin
            pix_cnt_d  = '0;
            clip_cnt_d = '0;
        end else begin
            if (pop) begin
                pix_cnt_d = pix_cnt_q + 17'd1;
            end
            if (clip_hit) begin
                clip_cnt_d = clip_cnt_q + 17'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            px_sr_q     <= '0;
            py_sr_q     <= '0;
            c_sr_q      <= '0;
            valid_lat_q <= 1'b0;
            err_q       <= 1'b0;
            cv_pend_q   <= 1'b0;
            cv_valid_q  <= 1'b0;
            cv_xi_q     <= '0;
            cv_yi_q     <= '0;
            cv_c_q      <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            done_pend_q <= 1'b0;
            pix_cnt_q   <= '0;
            clip_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            px_sr_q     <= px_sr_d;
            py_sr_q     <= py_sr_d;
            c_sr_q      <= c_sr_d;
            valid_lat_q <= valid_lat_d;
            err_q       <= err_d;
            cv_pend_q   <= cv_pend_d;
            cv_valid_q  <= cv_valid_d;
            cv_xi_q     <= cv_xi_d;
            cv_yi_q     <= cv_yi_d;
            cv_c_q      <= cv_c_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            done_pend_q <= done_pend_d;
            pix_cnt_q   <= pix_cnt_d;
            clip_cnt_q  <= clip_cnt_d;
        end
    end

    assign FB_WE    = !empty;
    assign FB_ADDR  = empty ? '0 : mem_q[rd_ptr_q][EW-1:16];
    assign FB_DATA  = empty ? '0 : mem_q[rd_ptr_q][15:0];
    assign TRI_DONE = tri_done;
    assign PIX_CNT  = pix_cnt_q;
    assign CLIP_CNT = clip_cnt_q;
    assign OVF      = ovf_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Scoreboard bench for pixel_writer: directed serial words, expected writes queued
// at stimulus time and checked by a monitor whenever a write is accepted.
module tb_pixel_writer;

    logic        CLK = 1'b0;
    logic        RST, PX, PY, C, FRAME, VALID, DONE, FB_READY;
    logic        FB_WE, TRI_DONE, OVF, ERR;
    logic [16:0] FB_ADDR, PIX_CNT, CLIP_CNT;
    logic [15:0] FB_DATA;

    always #5 CLK = ~CLK;

    pixel_writer #(
        .WIDTH(320), .HEIGHT(240), .ADDR_W(17), .FIFO_DEPTH(4), .FRAC(6)
    ) dut (
        .CLK(CLK), .RST(RST), .PX(PX), .PY(PY), .C(C), .FRAME(FRAME),
        .VALID(VALID), .DONE(DONE), .FB_WE(FB_WE), .FB_ADDR(FB_ADDR),
        .FB_DATA(FB_DATA), .FB_READY(FB_READY), .TRI_DONE(TRI_DONE),
        .PIX_CNT(PIX_CNT), .CLIP_CNT(CLIP_CNT), .OVF(OVF), .ERR(ERR)
    );

    typedef struct {
        logic [16:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          tri_cnt = 0;
    int          tri_cyc = -1;
    int          last_pop_cyc = -1;
    logic        tri_prev = 1'b0;
    logic [16:0] pix_at_tri = '0;
    logic [16:0] pix_after_tri = '1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [16:0] a, input logic [15:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: every accepted write must match the head of the expected queue.
    always @(negedge CLK) begin
        exp_t e;
        if (tri_prev) pix_after_tri = PIX_CNT;
        tri_prev = TRI_DONE && !RST;
        if (!RST && TRI_DONE) begin
            tri_cnt++;
            tri_cyc = cyc;
            pix_at_tri = PIX_CNT;
        end
        if (!RST && FB_WE && FB_READY) begin
            last_pop_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", FB_ADDR, FB_DATA);
            end else begin
                e = exp_q.pop_front();
                check("fb_addr", 32'(FB_ADDR), 32'(e.addr));
                check("fb_data", 32'(FB_DATA), 32'(e.data));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] px, input logic [15:0] py, input logic [15:0] c,
                        input logic v, input int nbits, input logic done_last);
        for (int i = 15; i > 15 - nbits; i--) begin
            PX    = px[i];
            PY    = py[i];
            C     = c[i];
            FRAME = (i == 15);
            VALID = v;
            DONE  = done_last && (i == 0);
            tick(1);
        end
        PX = 1'b0; PY = 1'b0; C = 1'b0; FRAME = 1'b0; VALID = 1'b0; DONE = 1'b0;
    endtask

    task automatic finish_tri();
        bit seen = 1'b0;
        DONE = 1'b1;
        tick(1);
        DONE = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge CLK);
            if (TRI_DONE) seen = 1'b1;
        end
        check("tri_done_seen", 32'(seen), 32'd1);
        @(negedge CLK);
        check("pix_cleared", 32'(PIX_CNT), 32'd0);
        check("clip_cleared", 32'(CLIP_CNT), 32'd0);
        check("tri_done_single", 32'(TRI_DONE), 32'd0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] bp_px [5];
        int t0;
        bp_px = '{16'h0000, 16'h0040, 16'h0080, 16'h00C0, 16'h0100};

        RST = 1'b1; PX = 1'b0; PY = 1'b0; C = 1'b0; FRAME = 1'b0;
        VALID = 1'b0; DONE = 1'b0; FB_READY = 1'b1;
        tick(3);
        check("rst_we", 32'(FB_WE), 32'd0);
        check("rst_addr", 32'(FB_ADDR), 32'd0);
        check("rst_data", 32'(FB_DATA), 32'd0);
        check("rst_tri", 32'(TRI_DONE), 32'd0);
        check("rst_cnts", 32'({PIX_CNT, CLIP_CNT}), 32'd0);
        check("rst_flags", 32'({OVF, ERR}), 32'd0);
        RST = 1'b0;
        tick(1);

        // In-range pixel with latency check: (10,5) -> 5*320+10
        expect_wr(17'd1610, 16'hF800);
        send(16'h0280, 16'h0140, 16'hF800, 1'b1, 16, 1'b0);
        check("we_t16", 32'(FB_WE), 32'd0);
        tick(1);
        check("we_t17", 32'(FB_WE), 32'd1);
        check("addr_t17", 32'(FB_ADDR), 32'd1610);
        tick(1);
        check("pix_cnt_1", 32'(PIX_CNT), 32'd1);

        // Discarded word, then two clipped words back to back
        send(16'h0280, 16'h0140, 16'h1234, 1'b0, 16, 1'b0);
        tick(3);
        check("discard_pix", 32'(PIX_CNT), 32'd1);
        check("discard_clip", 32'(CLIP_CNT), 32'd0);
        send(16'hFFC0, 16'h0140, 16'h1111, 1'b1, 16, 1'b0);
        send(16'h5000, 16'h0140, 16'h2222, 1'b1, 16, 1'b0);
        tick(3);
        check("clip_cnt_2", 32'(CLIP_CNT), 32'd2);
        check("clip_pix", 32'(PIX_CNT), 32'd1);
        finish_tri();

        // Backpressure: 4 queued, 5th dropped
        FB_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) expect_wr(17'(i), 16'hA000 + 16'(i));
            send(bp_px[i], 16'h0000, 16'hA000 + 16'(i), 1'b1, 16, 1'b0);
        end
        tick(3);
        check("ovf_set", 32'(OVF), 32'd1);
        check("bp_we_held", 32'(FB_WE), 32'd1);
        check("bp_head", 32'(FB_ADDR), 32'd0);
        FB_READY = 1'b1;
        tick(6);
        check("bp_pix_cnt", 32'(PIX_CNT), 32'd4);
        check("bp_drained", 32'(exp_q.size()), 32'd0);
        finish_tri();

        // Framing error: word restarted 8 cycles in; only the second word is written
        expect_wr(17'd12850, 16'h07E0);
        send(16'h0280, 16'h0140, 16'hF800, 1'b1, 8, 1'b0);
        check("err_before", 32'(ERR), 32'd0);
        send(16'h0C80, 16'h0A00, 16'h07E0, 1'b1, 16, 1'b0);
        check("err_set", 32'(ERR), 32'd1);
        check("we_t24", 32'(FB_WE), 32'd0);
        tick(1);
        check("we_t25", 32'(FB_WE), 32'd1);
        tick(2);
        check("err_pix", 32'(PIX_CNT), 32'd1);
        finish_tri();

        // End of triangle: DONE on bit 0 of the last word, drained with toggling READY
        FB_READY = 1'b0;
        expect_wr(17'd76799, 16'h5555);
        expect_wr(17'd0, 16'hFFFF);
        t0 = tri_cnt;
        send(16'h4FC0, 16'h3BC0, 16'h5555, 1'b1, 16, 1'b0);
        send(16'h0000, 16'h0000, 16'hFFFF, 1'b1, 16, 1'b1);
        tick(3);
        check("tri_wait_queued", 32'(tri_cnt - t0), 32'd0);
        check("tri_we_queued", 32'(FB_WE), 32'd1);
        for (int i = 0; i < 12; i++) begin
            FB_READY = ~FB_READY;
            tick(1);
        end
        FB_READY = 1'b1;
        tick(2);
        check("tri_once", 32'(tri_cnt - t0), 32'd1);
        check("tri_after_pop", 32'(tri_cyc), 32'(last_pop_cyc + 1));
        check("tri_pix_at_pulse", 32'(pix_at_tri), 32'd2);
        check("tri_pix_next", 32'(pix_after_tri), 32'd0);

        // Reset mid-stream with 3 entries queued
        FB_READY = 1'b0;
        send(16'h0040, 16'h0000, 16'h0001, 1'b1, 16, 1'b0);
        send(16'h0080, 16'h0000, 16'h0002, 1'b1, 16, 1'b0);
        send(16'h00C0, 16'h0000, 16'h0003, 1'b1, 16, 1'b0);
        send(16'h0100, 16'h0000, 16'h0004, 1'b1, 7, 1'b0);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        check("mrst_we", 32'(FB_WE), 32'd0);
        check("mrst_addr", 32'(FB_ADDR), 32'd0);
        check("mrst_data", 32'(FB_DATA), 32'd0);
        check("mrst_cnts", 32'({PIX_CNT, CLIP_CNT}), 32'd0);
        check("mrst_flags", 32'({OVF, ERR, TRI_DONE}), 32'd0);
        FB_READY = 1'b1;
        tick(4);
        check("mrst_no_we", 32'(FB_WE), 32'd0);
        // Fresh word with fractional bits truncated: (1.98, 1.98) -> 321
        expect_wr(17'd321, 16'h001F);
        send(16'h007F, 16'h007F, 16'h001F, 1'b1, 16, 1'b0);
        tick(3);
        check("fresh_pix", 32'(PIX_CNT), 32'd1);
        check("all_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_writer.md
# pixel_writer

Receiving end of the rasterizer's bit-serial pixel output. Deserializes the three 16-bit lanes (PX, PY, C), keeps only in-triangle pixels, converts Q10.6 coordinates to integer screen coordinates, and clips them to the screen. Surviving pixels are queued in a small FIFO and written to the framebuffer through a valid/ready write port. The block also reports end-of-triangle once every accepted pixel has been written.

## Interface
- WIDTH, 320: screen width in pixels.
- HEIGHT, 240: screen height in pixels.
- ADDR_W, 17: framebuffer address width.
- FIFO_DEPTH, 4: write-queue entries (power of two).
- FRAC, 6: fractional bits of the PX/PY words.

Ports:
- CLK  in  1: clock; everything is sampled on the rising edge.
- RST  in  1: synchronous, active-high reset.
- PX  in  1: serial x word, Q10.6, MSB first.
- PY  in  1: serial y word, Q10.6, MSB first.
- C  in  1: serial color word, RGB565, MSB first.
- FRAME  in  1: high in the cycle that carries bit 15 of a word.
- VALID  in  1: sampled only in the FRAME cycle; 1 means the word is an in-triangle pixel.
- DONE  in  1: one-cycle pulse marking end of the current triangle.
- FB_WE  out  1: write request.
- FB_ADDR  out  ADDR_W: write address.
- FB_DATA  out  16: write color.
- FB_READY  in  1: framebuffer accepts a write.
- TRI_DONE  out  1: one-cycle pulse; the triangle is fully written.
- PIX_CNT  out  17: pixels written for the current triangle.
- CLIP_CNT  out  17: pixels dropped by clipping for the current triangle.
- OVF  out  1: sticky; a pixel was dropped because the FIFO was full.
- ERR  out  1: sticky; FRAME arrived in the middle of a word.

## Operation
- Capture FSM has two states, IDLE and SHIFT.
  - IDLE → SHIFT when FRAME=1. In that cycle, bit 15 of each lane is shifted in, VALID is latched, and the bit counter is set to 14.
  - In SHIFT, one bit per lane is shifted each cycle and the counter decrements.
  - When the bit-0 cycle completes, the word is marked complete and the FSM returns to IDLE. If FRAME=1 in the cycle right after bit 0, a new word starts with no gap.
  - FRAME=1 while in SHIFT aborts the partial word, sets ERR, and restarts capture with that cycle as bit 15.
- Conversion happens in the register stage after a word completes:
  - xi = PX >>> FRAC and yi = PY >>> FRAC, both signed 10-bit.
  - A latched VALID=0 discards the word with no counters changed.
  - A pixel is in range when 0 ≤ xi < WIDTH and 0 ≤ yi < HEIGHT. Out-of-range pixels are dropped and CLIP_CNT increments.
  - For in-range pixels, addr = yi*WIDTH + xi, truncated to ADDR_W bits, and {addr, color} is pushed to the FIFO.
- FIFO rules:
  - A push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the pixel is dropped and OVF is set.
  - FB_WE is high whenever the FIFO is non-empty, and FB_ADDR/FB_DATA show the head entry.
  - A pop occurs when FB_WE and FB_READY are both 1; PIX_CNT increments on each pop.
- End of triangle:
  - DONE sets a done_pending flag.
  - TRI_DONE pulses in the first cycle that satisfies all of: done_pending=1, FSM in IDLE, no word waiting in the conversion stage, and FIFO empty.
  - Both counters clear on the cycle after the TRI_DONE pulse; done_pending clears with the pulse.
  - A DONE that arrives while done_pending is already set is absorbed, producing one pulse only.
- OVF and ERR clear only on reset.

## Timing
- Reset: FB_WE=0, TRI_DONE=0, OVF=0, ERR=0, PIX_CNT=0, CLIP_CNT=0, FIFO empty, FSM in IDLE, done_pending=0. FB_ADDR and FB_DATA are 0.
- RST=1 in the middle of a word discards the partial word and all FIFO contents.
- Latency, with FRAME at cycle t:
  - Bit 0 is sampled at t+15.
  - The conversion register is loaded at t+16.
  - The FIFO push happens at t+17.
  - FB_WE is high at t+17 if the FIFO was empty.
- Sustained back-to-back words (one every 16 cycles) never overflow while FB_READY=1.
- If a DONE pulse coincides with the bit-0 cycle of the last word, that word is still written before TRI_DONE.

## Test plan
- In-range pixel: PX=0x0280, PY=0x0140, C=0xF800, VALID=1 → FB_WE at t+17 with FB_ADDR=1610 and FB_DATA=0xF800; then PIX_CNT=1.
- Discard and clip:
  - VALID=0 word → no write, no count change.
  - PX=0xFFC0 (x=-1), then PX=0x5000 (x=320), VALID=1 → no write, CLIP_CNT=2.
- Backpressure: hold FB_READY=0 and send 5 valid words → 4 queued, 5th dropped, OVF=1. Then raise FB_READY → 4 writes in order, PIX_CNT=4.
- Framing error: FRAME at t and again at t+8 → ERR=1, first word lost. The word started at t+8 is written at t+25.
- End of triangle: DONE while 2 entries are queued and FB_READY toggles every other cycle → TRI_DONE exactly once, in the cycle after the last pop; the next cycle shows PIX_CNT=0.
- Reset mid-stream: RST at t+7 with 3 entries queued → no FB_WE after reset, all outputs at reset values. A fresh word afterwards is written correctly.
